bf_pair_scheduler: RTL and testbench
====================================

BF_PAIR_SCHEDULER -- requirements
Module: bf_pair_scheduler

Interface
REQ-001 SHALL have parameter X_WDTH, default 16: width of each real/imag part; complex words are 2*X_WDTH, {re, im}.
REQ-002 SHALL have parameter LOG_N, default 3: log2 of the frame length N.
REQ-003 SHALL have parameter STAGE, default 0: DIT stage index, range 0..LOG_N-1; butterfly span = 2^STAGE.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_data  input  2*X_WDTH  complex input sample, in natural frame order.
REQ-007 SHALL have port in_nd  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_rdy  output  1  block accepts samples this cycle.
REQ-009 SHALL have port tw_addr  output  LOG_N-1  twiddle ROM address, driven one cycle ahead of the matching x_nd.
REQ-010 SHALL have port w_in  input  2*X_WDTH  twiddle from the external 1-cycle-latency ROM.
REQ-011 SHALL have port xa  output  2*X_WDTH  butterfly operand XA.
REQ-012 SHALL have port xb  output  2*X_WDTH  butterfly operand XB.
REQ-013 SHALL have port w  output  2*X_WDTH  combinational pass-through of w_in.
REQ-014 SHALL have port m  output  LOG_N  frame index of XA; XB index = m + 2^STAGE.
REQ-015 SHALL have port x_nd  output  1  xa/xb/w/m are valid; never high on two consecutive cycles.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last butterfly of a frame.
REQ-017 SHALL have port err  output  1  sticky flag: in_nd was high while in_rdy was low.

Function
REQ-018 SHALL have two states, FILL and ISSUE; the state after reset is FILL.
REQ-019 SHALL, in FILL, drive in_rdy=1 and write in_data into buffer[cnt] on each in_nd, then increment cnt.
REQ-020 SHALL go from FILL to ISSUE on the cycle after the N-th sample is written; cnt wraps to 0.
REQ-021 SHALL, in ISSUE, drive in_rdy=0, ignore in_nd for storage, and set err=1 if in_nd=1.
REQ-022 SHALL, in ISSUE, step butterfly index k=0..N/2-1, one index per two cycles, using a phase bit that starts at 0.
REQ-023 SHALL, for index k, compute pos = k mod 2^STAGE and grp = k >> STAGE; ia = grp*2^(STAGE+1) + pos; ib = ia + 2^STAGE; twiddle index = pos << (LOG_N-1-STAGE).
REQ-024 SHALL, on a phase-0 cycle, drive registered tw_addr = twiddle index(k) and start reading buffer[ia] and buffer[ib].
REQ-025 SHALL, on the following phase-1 cycle, drive x_nd=1 with xa=buffer[ia], xb=buffer[ib], m=ia, and w=w_in.
REQ-026 SHALL use N cycles per ISSUE: the first tw_addr is at ISSUE cycle 0, the first x_nd at cycle 1, and the last x_nd at cycle N-1.
REQ-027 SHALL, on the cycle after the last x_nd, return to FILL with in_rdy=1 and frame_done=1 for exactly that cycle.
REQ-028 SHALL hold xa, xb, m and tw_addr at their last values when x_nd=0; consumers qualify on x_nd only.
REQ-029 SHALL pass data without arithmetic: no scaling, rounding or sign change of samples or twiddles.
REQ-030 SHALL keep buffer contents unchanged in ISSUE, so in_nd during ISSUE never corrupts the frame being issued.
REQ-031 SHALL accept in_nd on the same cycle frame_done is high, since in_rdy=1 on that cycle.

Reset
REQ-032 SHALL, while rst=1, force state=FILL, cnt=0, k=0, phase=0, in_rdy=1, x_nd=0, frame_done=0, err=0, tw_addr=0, xa=0, xb=0, m=0.
REQ-033 SHALL, on reset during ISSUE, abandon the partial frame and issue no further x_nd; buffer contents are don't-care.
REQ-034 SHALL clear err only by reset.

Verification (N=8, X_WDTH=16)
REQ-035 SHALL be tested with STAGE=0 and samples 0..7 sent back-to-back -> x_nd at ISSUE cycles 1,3,5,7; (m,xa,xb) = (0,0,1),(2,2,3),(4,4,5),(6,6,7); tw_addr=0 throughout.
REQ-036 SHALL be tested with STAGE=1 -> pairs (0,2),(1,3),(4,6),(5,7); tw_addr sequence 0,2,0,2.
REQ-037 SHALL be tested with STAGE=2 and w_in = 0x1000+tw_addr delayed one cycle -> pairs (0,4),(1,5),(2,6),(3,7); w on x_nd cycles = 0x1000,0x1001,0x1002,0x1003.
REQ-038 SHALL be tested with gapped in_nd (one valid per 3 cycles) -> ISSUE starts the cycle after the 8th sample, with results identical to REQ-035.
REQ-039 SHALL be tested with in_nd held high during ISSUE -> err=1 and stays 1, issued operands unchanged; frame_done pulses once, and the next frame fills normally.
REQ-040 SHALL be tested with rst pulsed at ISSUE cycle 4 -> no x_nd after reset, in_rdy=1, err=0, and a new 8-sample frame is issued correctly.

Source files
------------

// File: rtl/bf_pair_scheduler.sv
// Buffers one N-sample complex frame, then issues the radix-2 DIT butterfly
// operand pairs of one stage, one pair every two cycles, with twiddle addressing.
module bf_pair_scheduler #(
    parameter int X_WDTH = 16,
    parameter int LOG_N  = 3,
    parameter int STAGE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*X_WDTH-1:0]   in_data,
    input  logic                  in_nd,
    output logic                  in_rdy,
    output logic [LOG_N-2:0]      tw_addr,
    input  logic [2*X_WDTH-1:0]   w_in,
    output logic [2*X_WDTH-1:0]   xa,
    output logic [2*X_WDTH-1:0]   xb,
    output logic [2*X_WDTH-1:0]   w,
    output logic [LOG_N-1:0]      m,
    output logic                  x_nd,
    output logic                  frame_done,
    output logic                  err
);

    localparam int N     = 1 << LOG_N;
    localparam int TW_SH = LOG_N - 1 - STAGE;
    localparam logic [LOG_N-2:0] POS_MASK = (LOG_N-1)'((1 << STAGE) - 1);
    localparam logic [LOG_N-2:0] K_LAST   = (LOG_N-1)'(N/2 - 1);
    localparam logic [LOG_N-1:0] SPAN     = LOG_N'(1 << STAGE);
    localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N - 1);

    typedef enum logic {FILL, ISSUE} state_t;

    state_t                 state_q;
    logic [LOG_N-1:0]       cnt_q;
    logic [LOG_N-2:0]       k_q;
    logic                   phase_q;
    logic                   in_rdy_q;
    logic                   x_nd_q;
    logic                   frame_done_q;
    logic                   err_q;
    logic [LOG_N-2:0]       tw_addr_q;
    logic [2*X_WDTH-1:0]    xa_q;
    logic [2*X_WDTH-1:0]    xb_q;
    logic [LOG_N-1:0]       m_q;
    logic [2*X_WDTH-1:0]    mem_q [N];

    logic [LOG_N-1:0]       k_ext;
    logic [LOG_N-2:0]       pos;
    logic [LOG_N-2:0]       k_inc;
    logic [LOG_N-1:0]       ia_d;
    logic [LOG_N-1:0]       ib_d;
    logic [LOG_N-2:0]       tw_next_d;

    // Pair addresses: insert a zero bit at position STAGE of k to get ia.
    always_comb begin
        k_ext     = {1'b0, k_q};
        pos       = k_q & POS_MASK;
        ia_d      = ((k_ext >> STAGE) << (STAGE + 1)) | {1'b0, pos};
        ib_d      = ia_d | SPAN;
        k_inc     = k_q + (LOG_N-1)'(1);
        tw_next_d = (k_inc & POS_MASK) << TW_SH;
    end

    always_ff @(posedge clk) begin
        if (state_q == FILL && in_nd) begin
            mem_q[cnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            k_q          <= '0;
            phase_q      <= 1'b0;
            in_rdy_q     <= 1'b1;
            x_nd_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            tw_addr_q    <= '0;
            xa_q         <= '0;
            xb_q         <= '0;
            m_q          <= '0;
        end else begin
            x_nd_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (in_nd && !in_rdy_q) begin
                err_q <= 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (in_nd) begin
                        cnt_q <= cnt_q + LOG_N'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q   <= ISSUE;
                            in_rdy_q  <= 1'b0;
                            k_q       <= '0;
                            phase_q   <= 1'b0;
                            tw_addr_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        x_nd_q  <= 1'b1;
                        xa_q    <= mem_q[ia_d];
                        xb_q    <= mem_q[ib_d];
                        m_q     <= ia_d;
                    end else begin
                        phase_q <= 1'b0;
                        if (k_q == K_LAST) begin
                            state_q      <= FILL;
                            in_rdy_q     <= 1'b1;
                            frame_done_q <= 1'b1;
                            k_q          <= '0;
                        end else begin
                            // Twiddle for the next pair is presented one cycle before its x_nd.
                            k_q       <= k_inc;
                            tw_addr_q <= tw_next_d;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_rdy     = in_rdy_q;
    assign tw_addr    = tw_addr_q;
    assign xa         = xa_q;
    assign xb         = xb_q;
    assign w          = w_in;
    assign m          = m_q;
    assign x_nd       = x_nd_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bf_pair_scheduler.sv
// Bench for bf_pair_scheduler: three instances (STAGE 0,1,2) share one input
// stream and are compared cycle by cycle against a frame-level timeline model.
module tb_bf_pair_scheduler;

    localparam int XW    = 16;
    localparam int LOG_N = 3;
    localparam int N     = 8;
    localparam int NST   = 3;
    localparam int EW    = 3 + 3*32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_nd = 1'b0;

    logic        rdy_s  [NST];
    logic        xnd_s  [NST];
    logic        done_s [NST];
    logic        err_s  [NST];
    logic [1:0]  tw_s   [NST];
    logic [31:0] xa_s   [NST];
    logic [31:0] xb_s   [NST];
    logic [31:0] w_s    [NST];
    logic [2:0]  m_s    [NST];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NST; g++) begin : g_dut
        logic [31:0] w_rom, xa_l, xb_l, w_l;
        logic [1:0]  tw_l;
        logic [2:0]  m_l;
        logic        rdy_l, xnd_l, done_l, err_l;

        // External twiddle ROM with one cycle of latency.
        always @(posedge clk) w_rom <= 32'h1000 + {30'd0, tw_l};

        bf_pair_scheduler #(.X_WDTH(XW), .LOG_N(LOG_N), .STAGE(g)) u_dut (
            .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_rdy(rdy_l),
            .tw_addr(tw_l), .w_in(w_rom), .xa(xa_l), .xb(xb_l), .w(w_l), .m(m_l),
            .x_nd(xnd_l), .frame_done(done_l), .err(err_l)
        );

        assign rdy_s[g]  = rdy_l;
        assign xnd_s[g]  = xnd_l;
        assign done_s[g] = done_l;
        assign err_s[g]  = err_l;
        assign tw_s[g]   = tw_l;
        assign xa_s[g]   = xa_l;
        assign xb_s[g]   = xb_l;
        assign w_s[g]    = w_l;
        assign m_s[g]    = m_l;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          issue_start = 0;
    bit          issue_valid = 1'b0;
    bit          err_m = 1'b0;
    logic [31:0] fill_q [$];
    logic [31:0] frame  [N];
    logic [EW-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ia_of(input int s, input int k);
        int span = 1 << s;
        return (k / span) * 2 * span + (k % span);
    endfunction

    function automatic int tw_of(input int s, input int k);
        return (k % (1 << s)) << (LOG_N - 1 - s);
    endfunction

    function automatic bit model_busy();
        return issue_valid && cyc >= issue_start && cyc < issue_start + N;
    endfunction

    task automatic check_cycle();
        bit active, xnd_e, done_e;
        int c;
        logic [EW-1:0] e;
        active = model_busy();
        c      = cyc - issue_start;
        xnd_e  = active && (c % 2 == 1);
        done_e = issue_valid && cyc == issue_start + N;
        for (int g = 0; g < NST; g++) begin
            check_eq($sformatf("in_rdy s%0d c%0d", g, cyc), rdy_s[g], !active);
            check_eq($sformatf("x_nd s%0d c%0d", g, cyc), xnd_s[g], xnd_e);
            check_eq($sformatf("frame_done s%0d c%0d", g, cyc), done_s[g], done_e);
            check_eq($sformatf("err s%0d c%0d", g, cyc), err_s[g], err_m);
            if (active)
                check_eq($sformatf("tw_addr s%0d c%0d", g, cyc), tw_s[g], tw_of(g, c / 2));
            if (xnd_e) begin
                check_eq($sformatf("exp_avail s%0d c%0d", g, cyc), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("m s%0d c%0d", g, cyc), m_s[g], e[98:96]);
                    check_eq($sformatf("xa s%0d c%0d", g, cyc), xa_s[g], e[95:64]);
                    check_eq($sformatf("xb s%0d c%0d", g, cyc), xb_s[g], e[63:32]);
                    check_eq($sformatf("w s%0d c%0d", g, cyc), w_s[g], e[31:0]);
                end
            end
        end
    endtask

    // One clock cycle: check this cycle's outputs, then present this cycle's inputs.
    task automatic step(input bit nd, input logic [31:0] d);
        bit ready;
        int ia, ib;
        @(negedge clk);
        check_cycle();
        ready = !model_busy();
        if (nd && !ready) err_m = 1'b1;
        if (nd && ready) begin
            fill_q.push_back(d);
            if (fill_q.size() == N) begin
                for (int i = 0; i < N; i++) frame[i] = fill_q[i];
                fill_q.delete();
                issue_start = cyc + 1;
                issue_valid = 1'b1;
                for (int k = 0; k < N/2; k++) begin
                    for (int g = 0; g < NST; g++) begin
                        ia = ia_of(g, k);
                        ib = ia + (1 << g);
                        exp_q.push_back({3'(ia), frame[ia], frame[ib], 32'h1000 + 32'(tw_of(g, k))});
                    end
                end
            end
        end
        in_nd   = nd;
        in_data = d;
        cyc++;
    endtask

    task automatic do_reset();
        in_nd = 1'b0;
        rst   = 1'b1;
        #1;
        for (int g = 0; g < NST; g++) begin
            check_eq($sformatf("rst in_rdy s%0d", g), rdy_s[g], 1);
            check_eq($sformatf("rst x_nd s%0d", g), xnd_s[g], 0);
            check_eq($sformatf("rst frame_done s%0d", g), done_s[g], 0);
            check_eq($sformatf("rst err s%0d", g), err_s[g], 0);
            check_eq($sformatf("rst tw_addr s%0d", g), tw_s[g], 0);
            check_eq($sformatf("rst xa s%0d", g), xa_s[g], 0);
            check_eq($sformatf("rst xb s%0d", g), xb_s[g], 0);
            check_eq($sformatf("rst m s%0d", g), m_s[g], 0);
        end
        fill_q.delete();
        exp_q.delete();
        issue_valid = 1'b0;
        err_m       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Ramp 0..7 back-to-back.
        for (int i = 0; i < N; i++) step(1'b1, 32'(i));
        repeat (10) step(1'b0, '0);

        // Same ramp with one valid every three cycles.
        for (int i = 0; i < N; i++) begin
            step(1'b1, 32'(i));
            step(1'b0, $urandom);
            step(1'b0, $urandom);
        end
        repeat (10) step(1'b0, '0);

        // in_nd held high through ISSUE and into the next frame.
        repeat (24) step(1'b1, $urandom);
        repeat (12) step(1'b0, '0);

        // Reset during ISSUE cycle 4, then a clean frame.
        for (int i = 0; i < N; i++) step(1'b1, $urandom);
        repeat (5) step(1'b0, '0);
        do_reset();
        for (int i = 0; i < N; i++) step(1'b1, $urandom);
        repeat (10) step(1'b0, '0);

        // Random valid pattern with random data.
        repeat (60) step($urandom_range(0, 3) != 0, $urandom);
        repeat (12) step(1'b0, '0);

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
